// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port memory: IF vs. load/store (D).
// One transaction at a time (IDLE -> BUSY -> RESP); IF anti-starvation and a timeout watchdog.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 3,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              bus_err,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready
);

   localparam int unsigned SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int unsigned WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
   localparam logic [WC_W-1:0] WAIT_LIM   = WC_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state, state_nxt;
   logic              owner_d;
   logic [SC_W-1:0]   starve_cnt;
   logic [WC_W-1:0]   wait_cnt;
   logic              grant_d, grant_if, done, abort;

   // Arbitration and transaction sequencing
   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_if  = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
               grant_d = 1'b1;
            end else if (if_req) begin
               grant_if = 1'b1;
            end
            if (grant_d || grant_if) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (m_req && m_ready) begin
               done      = 1'b1;
               state_nxt = RESP;
            end else if (wait_cnt == WAIT_LIM) begin
               abort     = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         owner_d    <= 1'b0;
         starve_cnt <= '0;
         wait_cnt   <= '0;
         if_ack     <= 1'b0;
         if_rdata   <= '0;
         d_ack      <= 1'b0;
         d_rdata    <= '0;
         bus_err    <= 1'b0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
      end else begin
         state   <= state_nxt;
         if_ack  <= 1'b0;
         d_ack   <= 1'b0;
         bus_err <= 1'b0;

         if (grant_d || grant_if) begin
            owner_d  <= grant_d;
            m_req    <= 1'b1;
            m_we     <= grant_d & d_we;
            m_addr   <= grant_d ? d_addr : if_addr;
            m_wdata  <= grant_d ? d_wdata : '0;
            wait_cnt <= '0;
            // Only D wins against a waiting IF count toward starvation
            starve_cnt <= (grant_d && if_req) ? starve_cnt + SC_W'(1) : '0;
         end

         if (state == BUSY && !done && !abort) begin
            wait_cnt <= wait_cnt + WC_W'(1);
         end

         if (done || abort) begin
            m_req   <= 1'b0;
            if_ack  <= !owner_d;
            d_ack   <= owner_d;
            bus_err <= abort;
         end

         // Read data is only replaced on a successful completion
         if (done) begin
            if (!owner_d) begin
               if_rdata <= m_rdata;
            end else if (!m_we) begin
               d_rdata <= m_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory model plus expected-ack scoreboard.
module tb_mem_arbiter;

   logic        clk;
   logic        n_rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        bus_err;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ready;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          wt;
      logic [31:0] rdata;
      int          len;
   } mem_t;

   typedef struct {
      logic        is_d;
      logic        err;
      logic [31:0] rdata;
   } ack_t;

   mem_t mq[$];
   ack_t aq[$];

   int checks = 0;
   int fails  = 0;

   logic [31:0] if_model;
   logic [31:0] d_model;

   mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .n_rst(n_rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .bus_err(bus_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_mem(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int wt, input logic [31:0] rdata, input int len);
      mem_t e;
      e.addr = addr; e.we = we; e.wdata = wdata; e.wt = wt; e.rdata = rdata; e.len = len;
      mq.push_back(e);
   endtask

   task automatic push_ack(input logic is_d, input logic err, input logic [31:0] rdata);
      ack_t a;
      a.is_d = is_d; a.err = err; a.rdata = rdata;
      aq.push_back(a);
   endtask

   // Wait (bounded) for n acks; cycles = negedges elapsed until the last one
   task automatic wait_acks(input int n, output int cycles);
      int got;
      got    = 0;
      cycles = 0;
      while (got < n && cycles < 300) begin
         @(negedge clk);
         cycles++;
         if (if_ack || d_ack) got++;
      end
      if (got < n) begin
         checks++;
         fails++;
         $display("FAIL ack_wait got=%0d expected=%0d", got, n);
      end
   endtask

   // Memory model: checks each request against the expected queue and answers after wt waits
   initial begin
      mem_t e;
      bit   in_txn;
      int   w;
      m_ready = 1'b0;
      m_rdata = '0;
      in_txn  = 0;
      w       = 0;
      e       = '{addr: 0, we: 0, wdata: 0, wt: 0, rdata: 0, len: 1};
      forever begin
         @(negedge clk);
         m_ready = 1'b0;
         if (m_req === 1'b1) begin
            if (!in_txn) begin
               in_txn = 1;
               w      = 0;
               if (mq.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL mem_unexpected_req addr=0x%08h expected=none", m_addr);
                  e = '{addr: 0, we: 0, wdata: 0, wt: 0, rdata: 0, len: 1};
               end else begin
                  e = mq.pop_front();
                  chk("m_addr", m_addr, e.addr);
                  chk("m_we", 32'(m_we), 32'(e.we));
                  chk("m_wdata", m_wdata, e.wdata);
               end
            end
            if (w == e.wt) begin
               m_ready = 1'b1;
               m_rdata = e.rdata;
            end
            w++;
         end else if (in_txn) begin
            in_txn = 0;
            chk("m_req_len", 32'(w), 32'(e.len));
         end
      end
   end

   // Ack monitor / scoreboard
   initial begin
      ack_t a;
      forever begin
         @(negedge clk);
         if (if_ack || d_ack) begin
            chk("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
            if (aq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_ack if_ack=%0b d_ack=%0b expected=none", if_ack, d_ack);
            end else begin
               a = aq.pop_front();
               chk("ack_owner", 32'(d_ack), 32'(a.is_d));
               chk("bus_err", 32'(bus_err), 32'(a.err));
               chk(a.is_d ? "d_rdata" : "if_rdata", a.is_d ? d_rdata : if_rdata, a.rdata);
            end
         end
      end
   end

   initial begin
      int cyc;
      n_rst   = 1'b0;
      if_req  = 1'b0; if_addr = '0;
      d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      if_model = '0;
      d_model  = '0;

      // 1. Reset with random requester inputs
      repeat (2) begin
         if_req  = 1'($urandom); if_addr = $urandom;
         d_req   = 1'($urandom); d_we    = 1'($urandom);
         d_addr  = $urandom;     d_wdata = $urandom;
         @(negedge clk);
         chk("rst_if_ack", 32'(if_ack), 0);
         chk("rst_d_ack", 32'(d_ack), 0);
         chk("rst_bus_err", 32'(bus_err), 0);
         chk("rst_m_req", 32'(m_req), 0);
         chk("rst_m_we", 32'(m_we), 0);
         chk("rst_m_addr", m_addr, 0);
         chk("rst_m_wdata", m_wdata, 0);
         chk("rst_if_rdata", if_rdata, 0);
         chk("rst_d_rdata", d_rdata, 0);
      end
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      n_rst = 1'b1;
      @(negedge clk);

      // 2. Fetch, zero wait
      push_mem(32'h100, 1'b0, 32'h0, 0, 32'h0050_0093, 1);
      push_ack(1'b0, 1'b0, 32'h0050_0093);
      if_model = 32'h0050_0093;
      if_addr = 32'h100; if_req = 1'b1;
      wait_acks(1, cyc);
      if_req = 1'b0;
      chk("fetch_latency", 32'(cyc), 32'd2);
      @(negedge clk);

      // 3. Contention: D store first, then IF
      push_mem(32'h2000, 1'b1, 32'hDEAD_BEEF, 1, 32'h0, 2);
      push_ack(1'b1, 1'b0, d_model);
      push_mem(32'h104, 1'b0, 32'h0, 0, 32'h1111_1111, 1);
      push_ack(1'b0, 1'b0, 32'h1111_1111);
      if_model = 32'h1111_1111;
      d_addr = 32'h2000; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
      if_addr = 32'h104; if_req = 1'b1;
      wait_acks(1, cyc);
      chk("contention_first_d", 32'(d_ack), 32'd1);
      d_req = 1'b0;
      wait_acks(1, cyc);
      if_req = 1'b0;
      @(negedge clk);

      // 4. Starvation: D,D,D,IF,D,D,D,IF with both requests held
      d_addr = 32'h3000; d_we = 1'b0; d_wdata = 32'h5555_0000;
      if_addr = 32'h400;
      for (int i = 0; i < 8; i++) begin
         if (i == 3 || i == 7) begin
            push_mem(32'h400, 1'b0, 32'h0, i % 3, 32'hB000_0000 + 32'(i), (i % 3) + 1);
            push_ack(1'b0, 1'b0, 32'hB000_0000 + 32'(i));
            if_model = 32'hB000_0000 + 32'(i);
         end else begin
            push_mem(32'h3000, 1'b0, 32'h5555_0000, i % 3, 32'hA000_0000 + 32'(i), (i % 3) + 1);
            push_ack(1'b1, 1'b0, 32'hA000_0000 + 32'(i));
            d_model = 32'hA000_0000 + 32'(i);
         end
      end
      d_req = 1'b1; if_req = 1'b1;
      wait_acks(8, cyc);
      d_req = 1'b0; if_req = 1'b0;
      @(negedge clk);

      // 5. Timeout on a D load: 8 BUSY cycles, bus_err, d_rdata kept
      push_mem(32'h40, 1'b0, 32'h0, 1000, 32'hFFFF_FFFF, 8);
      push_ack(1'b1, 1'b1, d_model);
      d_addr = 32'h40; d_we = 1'b0; d_wdata = 32'h0; d_req = 1'b1;
      wait_acks(1, cyc);
      d_req = 1'b0;
      chk("timeout_latency", 32'(cyc), 32'd9);
      @(negedge clk);

      // 6. Reset in BUSY at wait_cnt=2, then the held fetch is served afresh
      push_mem(32'h600, 1'b0, 32'h0, 1000, 32'h0, 3);
      push_mem(32'h600, 1'b0, 32'h0, 1, 32'h0000_0066, 2);
      push_ack(1'b0, 1'b0, 32'h0000_0066);
      if_addr = 32'h600; if_req = 1'b1;
      cyc = 0;
      while (m_req !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("rst_busy_m_req_seen", 32'(m_req), 32'd1);
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      chk("rst_busy_m_req", 32'(m_req), 0);
      chk("rst_busy_if_ack", 32'(if_ack), 0);
      chk("rst_busy_if_rdata", if_rdata, 0);
      chk("rst_busy_d_rdata", d_rdata, 0);
      n_rst = 1'b1;
      wait_acks(1, cyc);
      if_req = 1'b0;

      repeat (5) @(negedge clk);
      chk("mem_queue_drained", 32'(mq.size()), 0);
      chk("ack_queue_drained", 32'(aq.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
